// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - Requester and data_memory signal bundle for dmem_arbiter (p0_lock/p1_lock exist only with DMEM_ARB_LOCK_EN)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // Port 0: CPU load/store unit
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    // Port 1: external loader / DMA path
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

`ifdef DMEM_ARB_LOCK_EN
    logic              p0_lock;
    logic              p1_lock;
`endif

    // data_memory side
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_address_wr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_address_rd;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
        input  p0_lock, p1_lock,
`endif
        output mem_wr, mem_address_wr, mem_din, mem_rd, mem_address_rd,
        input  mem_dout
    );

    // Requesters plus memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
        output p0_lock, p1_lock,
`endif
        input  mem_wr, mem_address_wr, mem_din, mem_rd, mem_address_rd,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - Two-port round-robin arbiter in front of data_memory (optional lock FSM with DMEM_ARB_LOCK_EN)
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_arbiter_if.slave bus
);

    // The lock counter needs at least one terminal count below MAX_LOCK
    if (MAX_LOCK < 2) begin : g_max_lock_check
        $error("dmem_arbiter: MAX_LOCK must be at least 2");
    end

    logic gnt0;
    logic gnt1;
    logic rr_gnt0;
    logic rr_gnt1;
    logic last_grant;   // 1 = port 1 was granted most recently
    logic rvalid0;
    logic rvalid1;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic             lock_timeout;
`endif

    // Plain round-robin choice: the port that did not win last time takes a collision
    always_comb begin
        rr_gnt0 = 1'b0;
        rr_gnt1 = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            if (last_grant) begin
                rr_gnt0 = 1'b1;
            end else begin
                rr_gnt1 = 1'b1;
            end
        end else begin
            rr_gnt0 = bus.p0_req;
            rr_gnt1 = bus.p1_req;
        end
    end

    // Final grant: nothing while in reset, lock owner only while locked
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
`ifdef DMEM_ARB_LOCK_EN
            case (state)
                LOCK0:   gnt0 = bus.p0_req;
                LOCK1:   gnt1 = bus.p1_req;
                default: begin
                    gnt0 = rr_gnt0;
                    gnt1 = rr_gnt1;
                end
            endcase
`else
            gnt0 = rr_gnt0;
            gnt1 = rr_gnt1;
`endif
        end
    end

    assign bus.p0_ack = gnt0;
    assign bus.p1_ack = gnt1;

    // Steer the granted port onto the memory write or read side; idle buses read as zero
    always_comb begin
        bus.mem_wr         = 1'b0;
        bus.mem_address_wr = '0;
        bus.mem_din        = '0;
        bus.mem_rd         = 1'b0;
        bus.mem_address_rd = '0;
        if (gnt0) begin
            if (bus.p0_we) begin
                bus.mem_wr         = 1'b1;
                bus.mem_address_wr = bus.p0_addr;
                bus.mem_din        = bus.p0_wdata;
            end else begin
                bus.mem_rd         = 1'b1;
                bus.mem_address_rd = bus.p0_addr;
            end
        end else if (gnt1) begin
            if (bus.p1_we) begin
                bus.mem_wr         = 1'b1;
                bus.mem_address_wr = bus.p1_addr;
                bus.mem_din        = bus.p1_wdata;
            end else begin
                bus.mem_rd         = 1'b1;
                bus.mem_address_rd = bus.p1_addr;
            end
        end
    end

    // Remember the last winner and flag which port owns next cycle's memory read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~bus.p0_we;
            rvalid1 <= gnt1 & ~bus.p1_we;
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
`ifdef DMEM_ARB_LOCK_EN
            // A forced release counts as a win for the holder so the other port goes next
            if (lock_timeout) begin
                last_grant <= (state == LOCK1);
            end
`endif
        end
    end

    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rvalid0 ? bus.mem_dout : '0;
    assign bus.p1_rdata  = rvalid1 ? bus.mem_dout : '0;

`ifdef DMEM_ARB_LOCK_EN
    // Lock state and hold-time counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // Enter a lock on a locked accept; leave on unlock, withdrawn request or hold timeout
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        lock_timeout  = 1'b0;
        case (state)
            IDLE: begin
                lock_cnt_next = '0;
                if (gnt0 && bus.p0_lock) begin
                    state_next = LOCK0;
                end else if (gnt1 && bus.p1_lock) begin
                    state_next = LOCK1;
                end
            end
            LOCK0: begin
                if ((gnt0 && !bus.p0_lock) || !bus.p0_req) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                end else if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    lock_timeout  = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt + 1'b1;
                end
            end
            LOCK1: begin
                if ((gnt1 && !bus.p1_lock) || !bus.p1_req) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                end else if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    lock_timeout  = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt + 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end
        endcase
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - Scoreboard testbench for dmem_arbiter with a data_memory model
module tb_dmem_arbiter;
    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 16;

    typedef struct {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Requester drive
    logic [1:0] req_v = 2'b00;
    cmd_t       cur [2];
    assign bus.p0_req   = req_v[0];
    assign bus.p0_we    = cur[0].we;
    assign bus.p0_addr  = cur[0].addr;
    assign bus.p0_wdata = cur[0].data;
    assign bus.p1_req   = req_v[1];
    assign bus.p1_we    = cur[1].we;
    assign bus.p1_addr  = cur[1].addr;
    assign bus.p1_wdata = cur[1].data;
`ifdef DMEM_ARB_LOCK_EN
    assign bus.p0_lock  = cur[0].lock;
    assign bus.p1_lock  = cur[1].lock;
`endif

    // data_memory: synchronous write, registered read, no reset
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_address_wr] <= bus.mem_din;
        if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_address_rd];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    exp_t eq0[$];
    exp_t eq1[$];
    cmd_t cq0[$];
    cmd_t cq1[$];
    int   m_last = 1;
`ifdef DMEM_ARB_LOCK_EN
    int   m_lk  = -1;
    int   m_cnt = 0;
`endif
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   withdraw_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic lock, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.lock = lock; c.addr = a; c.data = d;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                  AW'($urandom_range(0, 15)), DW'($urandom));
    endfunction

    // After an edge: retire the accepted request, maybe withdraw one, start queued ones
    task automatic refill(input int g);
        for (int p = 0; p < 2; p++) begin
            bit dropped = 0;
            if (g == p) begin
                req_v[p] = 1'b0;
            end else if (withdraw_en && req_v[p] && $urandom_range(0, 7) == 0) begin
                req_v[p] = 1'b0;
                dropped = 1;
            end
            if (!req_v[p] && !dropped) begin
                if (p == 0 && cq0.size() > 0) begin
                    cur[0] = cq0.pop_front(); req_v[0] = 1'b1;
                end else if (p == 1 && cq1.size() > 0) begin
                    cur[1] = cq1.pop_front(); req_v[1] = 1'b1;
                end
            end
        end
    endtask

    // One cycle: predict the grant from the arbitration rules, check the DUT, update the model
    task automatic step();
        int            g;
        int            lk;
        logic [1:0]    rq;
        logic          e_wr, e_rd;
        logic [AW-1:0] e_aw, e_ar;
        logic [DW-1:0] e_din;
        @(negedge clk);
        rq = req_v; g = -1; lk = -1;
`ifdef DMEM_ARB_LOCK_EN
        lk = m_lk;
`endif
        if (reset_n) begin
            if (lk >= 0) begin
                if (rq[lk]) g = lk;
            end else if (rq == 2'b11) g = (m_last == 1) ? 0 : 1;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
        end
        e_wr = 0; e_rd = 0; e_aw = '0; e_ar = '0; e_din = '0;
        if (g >= 0) begin
            if (cur[g].we) begin e_wr = 1; e_aw = cur[g].addr; e_din = cur[g].data; end
            else begin e_rd = 1; e_ar = cur[g].addr; end
        end
        chk("p0_ack", bus.p0_ack, g == 0);
        chk("p1_ack", bus.p1_ack, g == 1);
        chk("mem_wr", bus.mem_wr, e_wr);
        chk("mem_rd", bus.mem_rd, e_rd);
        chk("mem_address_wr", bus.mem_address_wr, e_aw);
        chk("mem_address_rd", bus.mem_address_rd, e_ar);
        chk("mem_din", bus.mem_din, e_din);
        if (g >= 0) begin
            m_last = g;
            if (cur[g].we) ref_mem[cur[g].addr] = cur[g].data;
            else if (g == 0) eq0.push_back('{cyc + 1, ref_mem[cur[0].addr]});
            else eq1.push_back('{cyc + 1, ref_mem[cur[1].addr]});
        end
`ifdef DMEM_ARB_LOCK_EN
        if (reset_n) begin
            if (m_lk < 0) begin
                if (g >= 0 && cur[g].lock) begin m_lk = g; m_cnt = 0; end
            end else if ((g == m_lk && !cur[m_lk].lock) || !rq[m_lk]) begin
                m_lk = -1; m_cnt = 0;
            end else if (m_cnt == MAX_LOCK - 1) begin
                m_last = m_lk; m_lk = -1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
`endif
        @(posedge clk);
        #1;
        refill(g);
    endtask

    // Read-return monitor for one port
    task automatic mon_port(input int p);
        logic          v;
        logic [DW-1:0] d;
        exp_t          e;
        int            n;
        v = (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
        d = (p == 0) ? bus.p0_rdata  : bus.p1_rdata;
        n = (p == 0) ? eq0.size() : eq1.size();
        if (v) begin
            if (n == 0) begin
                chk($sformatf("p%0d_rvalid_unexpected", p), 1, 0);
            end else begin
                if (p == 0) e = eq0.pop_front(); else e = eq1.pop_front();
                chk($sformatf("p%0d_rvalid_cycle", p), cyc, e.cyc);
                chk($sformatf("p%0d_rdata", p), d, e.data);
            end
        end else begin
            chk($sformatf("p%0d_rdata_idle", p), d, 0);
            if (n > 0) begin
                if (p == 0) e = eq0[0]; else e = eq1[0];
                if (e.cyc <= cyc) begin
                    chk($sformatf("p%0d_rvalid_missing", p), 0, 1);
                    if (p == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_port(0);
            mon_port(1);
        end
    end

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        eq0.delete();
        eq1.delete();
        m_last = 1;
`ifdef DMEM_ARB_LOCK_EN
        m_lk = -1; m_cnt = 0;
`endif
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        refill(-1);
        while ((cq0.size() != 0 || cq1.size() != 0 || req_v != 2'b00) && n < max) begin
            step();
            n++;
        end
        chk("drain_within_budget", (n < max), 1);
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem[i]     <= v;
            ref_mem[i]  = v;
        end
        cur[0] = mk(0, 0, '0, '0);
        cur[1] = mk(0, 0, '0, '0);
        do_reset(3);

        // Single port write then read-back
        cq0.push_back(mk(1, 0, 8'h10, 16'hBEEF));
        cq0.push_back(mk(0, 0, 8'h10, 16'h0000));
        drain(20);
        chk("mem_0x10", mem[8'h10], 16'hBEEF);

        // Collision after reset: both ports read every cycle
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            cq0.push_back(mk(0, 0, AW'(8'h50 + i), '0));
            cq1.push_back(mk(0, 0, AW'(8'h60 + i), '0));
        end
        drain(40);

        // Simultaneous p1 write and p0 read of the same word
        do_reset(2);
        cq1.push_back(mk(1, 0, 8'h20, 16'h1234));
        cq0.push_back(mk(0, 0, 8'h20, '0));
        cq0.push_back(mk(0, 0, 8'h20, '0));
        drain(20);
        chk("mem_0x20", mem[8'h20], 16'h1234);

        // Reset asserted in the cycle after a read accept, with a write waiting
        cq0.push_back(mk(0, 0, 8'h40, '0));
        refill(-1);
        step();
        cq1.push_back(mk(1, 0, 8'h40, 16'hDEAD));
        do_reset(3);
        chk("mem_0x40_untouched", mem[8'h40], ref_mem[8'h40]);
        drain(20);
        cq0.push_back(mk(0, 0, 8'h40, '0));
        drain(20);
        chk("mem_0x40_after", mem[8'h40], 16'hDEAD);

`ifdef DMEM_ARB_LOCK_EN
        // Locked read-modify-write on p0 while p1 keeps requesting
        do_reset(2);
        cq0.push_back(mk(0, 1, 8'h30, '0));
        cq0.push_back(mk(1, 0, 8'h30, 16'h5A5A));
        for (int i = 0; i < 3; i++) cq1.push_back(mk(0, 0, 8'h30, '0));
        drain(30);

        // Lock held past the timeout
        do_reset(2);
        for (int i = 0; i < 20; i++) cq0.push_back(mk(0, 1, AW'(8'h70 + i), '0));
        for (int i = 0; i < 2; i++) cq1.push_back(mk(0, 0, AW'(8'h90 + i), '0));
        drain(100);
`endif

        // Randomized mixed traffic on a small address window
        do_reset(2);
        withdraw_en = 1;
        repeat (600) begin
            if (cq0.size() == 0 && $urandom_range(0, 2) != 0) cq0.push_back(rnd_cmd());
            if (cq1.size() == 0 && $urandom_range(0, 2) != 0) cq1.push_back(rnd_cmd());
            step();
        end
        withdraw_en = 0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
